dsc_mul_seq: RTL and testbench

Hardware requester for the dsc_mul deterministic stochastic multiplier. It accepts operand pairs over a valid/ready handshake and sequences the multiplier's rst/en controls. It waits for the multiplier's ov completion flag, captures z, checks it against an exact binary product, and reports the result with its cycle count. It also keeps running operation and cycle totals, so average latency can be read in hardware rather than computed by a bench.

---
 rtl/dsc_mul_seq.sv | 134 +++++++++++++
 tb/tb_dsc_mul_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: requester for the dsc_mul stochastic multiplier.
// Accepts an operand pair, clears the multiplier for one cycle, enables it
// until its ov flag (or a terminal cycle count), then presents the captured
// product with its cycle count and an exact-product check. Running totals of
// completed operations and cycles are kept for average-latency readout.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high only in IDLE and out_valid only in DONE. Upstream holds
// in_a/in_b/in_valid until in_ready; out_* are held while out_valid && !out_ready.
// The FSM state is fully decoded on in_ready/out_valid/mul_en for observation.
module dsc_mul_seq #(
  parameter int NUM_BITS  = 4,
  parameter int CYC_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_BITS-1:0]     in_a,
  input  logic [NUM_BITS-1:0]     in_b,
  output logic                    mul_rst,
  output logic                    mul_en,
  output logic [NUM_BITS-1:0]     mul_a,
  output logic [NUM_BITS-1:0]     mul_b,
  input  logic [2*NUM_BITS-1:0]   mul_z,
  input  logic                    mul_ov,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*NUM_BITS-1:0]   out_z,
  output logic [CYC_WIDTH-1:0]    out_cycles,
  output logic                    out_err,
  output logic                    out_timeout,
  output logic [CYC_WIDTH-1:0]    stat_ops,
  output logic [2*CYC_WIDTH-1:0]  stat_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CYC_WIDTH-1:0]   CNT_MAX = '1;
  localparam logic [CYC_WIDTH-1:0]   OPS_MAX = '1;
  localparam logic [2*CYC_WIDTH-1:0] CYC_MAX = '1;

  state_t                 state;
  state_t                 state_next;
  logic [CYC_WIDTH-1:0]   count;
  logic [CYC_WIDTH-1:0]   cnt_inc;
  logic [2*NUM_BITS-1:0]  product;
  logic [2*CYC_WIDTH:0]   cyc_sum;
  logic                   terminal;

  // The count seen in a RUN cycle includes that cycle, so the first RUN cycle counts 1.
  assign cnt_inc  = count + 1'b1;
  assign terminal = (cnt_inc == CNT_MAX);
  assign product  = {{NUM_BITS{1'b0}}, mul_a} * {{NUM_BITS{1'b0}}, mul_b};
  assign cyc_sum  = {1'b0, stat_cycles} + {{(CYC_WIDTH+1){1'b0}}, out_cycles};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mul_en    = (state == RUN);
  assign mul_rst   = (state != RUN);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; ov takes priority over the terminal count (both end RUN).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CLR;
      CLR:     state_next = RUN;
      RUN:     if (mul_ov || terminal) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, cycle counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a       <= '0;
      mul_b       <= '0;
      count       <= '0;
      out_z       <= '0;
      out_cycles  <= '0;
      out_err     <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
          end
        end
        CLR: count <= '0;
        RUN: begin
          count <= cnt_inc;
          if (mul_ov) begin
            out_z       <= mul_z;
            out_cycles  <= cnt_inc;
            out_err     <= (mul_z != product);
            out_timeout <= 1'b0;
          end else if (terminal) begin
            out_z       <= mul_z;
            out_cycles  <= cnt_inc;
            out_err     <= 1'b1;
            out_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating running totals, stepped once per delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops    <= '0;
      stat_cycles <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_ops != OPS_MAX) stat_ops <= stat_ops + 1'b1;
      stat_cycles <= cyc_sum[2*CYC_WIDTH] ? CYC_MAX : cyc_sum[2*CYC_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural multiplier stub.
// CYC_WIDTH is 8 so the terminal count (255) is reachable quickly.
module tb_dsc_mul_seq;

  localparam int NB = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NB-1:0]   in_a;
  logic [NB-1:0]   in_b;
  logic            mul_rst;
  logic            mul_en;
  logic [NB-1:0]   mul_a;
  logic [NB-1:0]   mul_b;
  logic [2*NB-1:0] mul_z;
  logic            mul_ov;
  logic            out_valid;
  logic            out_ready;
  logic [2*NB-1:0] out_z;
  logic [CW-1:0]   out_cycles;
  logic            out_err;
  logic            out_timeout;
  logic [CW-1:0]   stat_ops;
  logic [2*CW-1:0] stat_cycles;

  int checks   = 0;
  int failures = 0;
  logic [2*NB-1:0] exp_q[$];

  // Stub controls: z returned and enabled cycle on which ov rises (0 = never).
  logic [2*NB-1:0] stub_z;
  int              ov_at;
  int              en_cnt;

  dsc_mul_seq #(.NUM_BITS(NB), .CYC_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_cycles(out_cycles), .out_err(out_err), .out_timeout(out_timeout),
    .stat_ops(stat_ops), .stat_cycles(stat_cycles)
  );

  // Clock
  always #5 clk = ~clk;

  // Multiplier stub: counts enabled cycles since its last reset.
  always @(posedge clk or posedge rst) begin
    if (rst || mul_rst) en_cnt <= 0;
    else if (mul_en)    en_cnt <= en_cnt + 1;
  end
  assign mul_ov = mul_en && (ov_at != 0) && (en_cnt == ov_at - 1);
  assign mul_z  = stub_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Offer a pair, then confirm one CLR cycle followed by RUN.
  task automatic start_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [2*NB-1:0] z, input int ov);
    int w;
    w = 0;
    stub_z = z;
    ov_at  = ov;
    exp_q.push_back(z);
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("accept_wait", 0, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("clr_mul_rst", mul_rst, 1);
    check("clr_mul_en", mul_en, 0);
    check("clr_in_ready", in_ready, 0);
    check("mul_a", mul_a, a);
    check("mul_b", mul_b, b);
    @(negedge clk);
    check("run_mul_rst", mul_rst, 0);
    check("run_mul_en", mul_en, 1);
  endtask

  // From the first RUN negedge, out_valid is due n negedges later.
  task automatic expect_done(input int n, input int cyc, input logic err, input logic tmo);
    int cnt;
    logic [2*NB-1:0] ez;
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, n);
    check("out_valid", out_valid, 1);
    check("out_cycles", out_cycles, cyc);
    check("out_err", out_err, err);
    check("out_timeout", out_timeout, tmo);
    if (exp_q.size() == 0) check("sb_empty", 0, 1);
    else begin
      ez = exp_q.pop_front();
      check("out_z", out_z, ez);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    stub_z = '0; ov_at = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_mul_en", mul_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_stat_ops", stat_ops, 0);
    check("rst_stat_cycles", stat_cycles, 0);
    rst = 1'b0;

    // ov on the 255th cycle coincides with the terminal count: ov wins.
    start_op(4'd15, 4'd15, 8'd225, 255);
    expect_done(255, 255, 1'b0, 1'b0);
    finish_op();
    check("t1_stat_ops", stat_ops, 1);
    check("t1_stat_cycles", stat_cycles, 255);

    // Wrong product from the multiplier.
    start_op(4'd15, 4'd15, 8'd224, 3);
    expect_done(3, 3, 1'b1, 1'b0);
    finish_op();
    check("t2_stat_cycles", stat_cycles, 258);

    // Back-pressure: result held, new offer ignored, stats frozen.
    start_op(4'd3, 4'd5, 8'd15, 10);
    expect_done(10, 10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  begin in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; end
      if (i == 10) in_valid = 1'b0;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_z", out_z, 15);
      check("hold_in_ready", in_ready, 0);
      check("hold_stat_ops", stat_ops, 2);
    end
    check("hold_mul_a", mul_a, 3);
    finish_op();
    check("t3_stat_ops", stat_ops, 3);
    check("t3_stat_cycles", stat_cycles, 268);

    // Multiplier never completes.
    start_op(4'd2, 4'd7, 8'd0, 0);
    expect_done(255, 255, 1'b1, 1'b1);
    finish_op();

    // Back-to-back run from clean stats.
    do_reset();
    check("t5_rst_stat_ops", stat_ops, 0);
    start_op(4'd4, 4'd6, 8'd24, 10);
    expect_done(10, 10, 1'b0, 1'b0);
    finish_op();
    start_op(4'd5, 4'd5, 8'd25, 20);
    expect_done(20, 20, 1'b0, 1'b0);
    finish_op();
    start_op(4'd7, 4'd9, 8'd63, 30);
    expect_done(30, 30, 1'b0, 1'b0);
    finish_op();
    check("t5_stat_ops", stat_ops, 3);
    check("t5_stat_cycles", stat_cycles, 60);

    // Reset during RUN cycle 5 aborts with no result.
    start_op(4'd1, 4'd1, 8'd1, 10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_mul_en", mul_en, 0);
    check("abort_mul_rst", mul_rst, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_stat_ops", stat_ops, 0);
    check("abort_stat_cycles", stat_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    start_op(4'd6, 4'd2, 8'd12, 7);
    expect_done(7, 7, 1'b0, 1'b0);
    finish_op();
    check("t6_stat_ops", stat_ops, 1);
    check("t6_stat_cycles", stat_cycles, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
